// File: rtl/mtr_cmd_shaper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mtr_cmd_shaper
//  Description : Turns signed left/right drive commands into magnitude plus
//                direction for the motor PWM driver. Each side has a slew
//                limiter, a zero-crossing dwell before any reversal, optional
//                deadband offset and saturation to 11 bits.
//                Optional feature macro: MTR_SHAPER_DEADBAND_EN (adds MIN_DUTY
//                to every nonzero magnitude).
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_cmd_shaper #(
    parameter int SLEW_DIV = 1024,
    parameter int STEP     = 16,
    parameter int MIN_DUTY = 64,
    parameter int DWELL    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [11:0] lft_cmd,
    input  logic signed [11:0] rght_cmd,
    output logic [10:0]        lft_spd,
    output logic               lft_rev,
    output logic [10:0]        rght_spd,
    output logic               rght_rev,
    output logic               settled
);

    localparam int              PW          = $clog2(SLEW_DIV);
    localparam int              DW          = $clog2(DWELL + 1);
    localparam logic [PW-1:0]   C_PRESC_MAX = PW'(SLEW_DIV - 1);
    localparam logic [12:0]     C_STEP      = 13'(STEP);
    localparam logic [DW-1:0]   C_DWELL     = DW'(DWELL);
    localparam logic [12:0]     C_SPD_MAX   = 13'd2047;
`ifdef MTR_SHAPER_DEADBAND_EN
    localparam logic [12:0]     C_MIN_DUTY  = 13'(MIN_DUTY);
`else
    // Deadband compensation is compiled out; the parameter is kept for a
    // stable interface only.
    logic w_unused_min_duty;
    assign w_unused_min_duty = |13'(MIN_DUTY);
`endif

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [PW-1:0]      r_presc;
    logic               w_tick;
    logic               r_settled;
    logic signed [11:0] w_tgt [2];
    logic [10:0]        w_spd [2];
    logic [1:0]         w_rev;
    logic [1:0]         w_side_ok;

    assign w_tgt[0] = lft_cmd;
    assign w_tgt[1] = rght_cmd;
    assign w_tick   = (r_presc == C_PRESC_MAX);

    // Free-running slew prescaler shared by both sides, independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            state_t             r_state;
            state_t             w_state_nxt;
            logic signed [11:0] r_cur;
            logic signed [11:0] w_cur_nxt;
            logic               r_dir;
            logic               w_dir_nxt;
            logic [DW-1:0]      r_dwell;
            logic [DW-1:0]      w_dwell_nxt;
            logic [10:0]        r_spd;
            logic               r_rev;
            logic signed [12:0] w_cur_x;
            logic signed [12:0] w_tgt_x;
            logic signed [12:0] w_diff;
            logic signed [12:0] w_new;
            logic [12:0]        w_absdiff;
            logic [12:0]        w_mv;
            logic [12:0]        w_mag;
            logic [12:0]        w_duty;
            logic [10:0]        w_spd_nxt;
            logic               w_tgt_nz;
            logic               w_opp;
            logic               w_to_hold;

            // Slew step: difference is taken in 13 bits so full-scale swings
            // cannot wrap, then clipped to STEP.
            assign w_cur_x   = {r_cur[11], r_cur};
            assign w_tgt_x   = {w_tgt[gi][11], w_tgt[gi]};
            assign w_diff    = w_tgt_x - w_cur_x;
            assign w_absdiff = w_diff[12] ? $unsigned(-w_diff) : $unsigned(w_diff);
            assign w_mv      = (w_absdiff > C_STEP) ? C_STEP : w_absdiff;
            assign w_new     = w_diff[12] ? (w_cur_x - $signed(w_mv))
                                          : (w_cur_x + $signed(w_mv));

            // A nonzero target of the other sign than dir is a reversal; it
            // must stop at zero (from rest, or when the step reaches/crosses 0).
            assign w_tgt_nz  = (w_tgt[gi] != 12'sd0);
            assign w_opp     = w_tgt_nz && (w_tgt[gi][11] != r_dir);
            assign w_to_hold = w_opp && ((r_cur == 12'sd0) || (w_new == 13'sd0) ||
                                         (w_new[12] != r_cur[11]));

            // Next-state logic for the RUN/HOLD slew FSM
            always_comb begin
                w_state_nxt = r_state;
                w_cur_nxt   = r_cur;
                w_dir_nxt   = r_dir;
                w_dwell_nxt = r_dwell;
                if (!en) begin
                    w_state_nxt = ST_RUN;
                    w_cur_nxt   = '0;
                    w_dwell_nxt = '0;
                end else if (w_tick) begin
                    case (r_state)
                        ST_RUN: begin
                            if (w_to_hold) begin
                                w_state_nxt = ST_HOLD;
                                w_cur_nxt   = '0;
                                w_dwell_nxt = C_DWELL;
                            end else begin
                                w_cur_nxt = $signed(w_new[11:0]);
                            end
                        end
                        ST_HOLD: begin
                            // The dwell always runs to completion; the new
                            // direction is taken from the target at its end.
                            w_cur_nxt   = '0;
                            w_dwell_nxt = r_dwell - 1'b1;
                            if (r_dwell == DW'(1)) begin
                                w_state_nxt = ST_RUN;
                                if (w_tgt_nz) begin
                                    w_dir_nxt = w_tgt[gi][11];
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = ST_RUN;
                        end
                    endcase
                end
            end

            // Magnitude mapping; |-2048| = 2048 still fits in 13 bits
            assign w_mag = r_cur[11] ? $unsigned(-w_cur_x) : $unsigned(w_cur_x);
`ifdef MTR_SHAPER_DEADBAND_EN
            assign w_duty = w_mag + C_MIN_DUTY;
`else
            assign w_duty = w_mag;
`endif
            assign w_spd_nxt = (r_cur == 12'sd0)      ? 11'd0   :
                               (w_duty > C_SPD_MAX)   ? 11'h7FF : w_duty[10:0];

            // FSM state, command, direction and dwell registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_RUN;
                    r_cur   <= '0;
                    r_dir   <= 1'b0;
                    r_dwell <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cur   <= w_cur_nxt;
                    r_dir   <= w_dir_nxt;
                    r_dwell <= w_dwell_nxt;
                end
            end

            // Registered driver outputs, one clock behind cur/dir
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_spd <= '0;
                    r_rev <= 1'b0;
                end else begin
                    r_spd <= w_spd_nxt;
                    r_rev <= r_dir;
                end
            end

            assign w_spd[gi]     = r_spd;
            assign w_rev[gi]     = r_rev;
            assign w_side_ok[gi] = (r_cur == w_tgt[gi]) && (r_state == ST_RUN);
        end
    endgenerate

    // Settled flag: both sides on target and neither in a dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settled <= 1'b1;
        end else begin
            r_settled <= &w_side_ok;
        end
    end

    assign lft_spd  = w_spd[0];
    assign lft_rev  = w_rev[0];
    assign rght_spd = w_spd[1];
    assign rght_rev = w_rev[1];
    assign settled  = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_mtr_cmd_shaper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mtr_cmd_shaper
//  Description : Self-checking bench for mtr_cmd_shaper. A tick-level
//                integer model of the shaping rules predicts all outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_cmd_shaper;

    localparam int SLEW_DIV = 4;
    localparam int STEP     = 16;
    localparam int MIN_DUTY = 64;
    localparam int DWELL    = 4;
`ifdef MTR_SHAPER_DEADBAND_EN
    localparam int DB = MIN_DUTY;
`else
    localparam int DB = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic signed [11:0] lft_cmd = '0;
    logic signed [11:0] rght_cmd = '0;
    logic [10:0]        lft_spd;
    logic               lft_rev;
    logic [10:0]        rght_spd;
    logic               rght_rev;
    logic               settled;
    logic [24:0]        obs;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (plain integers)
    int m_cur [2];
    bit m_dir [2];
    bit m_hold[2];
    int m_dw  [2];
    int m_presc;
    int m_spd [2];
    bit m_rev [2];
    bit m_set;

    mtr_cmd_shaper #(
        .SLEW_DIV (SLEW_DIV),
        .STEP     (STEP),
        .MIN_DUTY (MIN_DUTY),
        .DWELL    (DWELL)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .lft_cmd  (lft_cmd),
        .rght_cmd (rght_cmd),
        .lft_spd  (lft_spd),
        .lft_rev  (lft_rev),
        .rght_spd (rght_spd),
        .rght_rev (rght_rev),
        .settled  (settled)
    );

    assign obs = {lft_spd, lft_rev, rght_spd, rght_rev, settled};

    always #5 clk = ~clk;

    function automatic int duty(int c);
        int a;
        if (c == 0) return 0;
        a = (c < 0) ? -c : c;
        a += DB;
        return (a > 2047) ? 2047 : a;
    endfunction

    function automatic logic [24:0] exp_vec();
        return {11'(m_spd[0]), m_rev[0], 11'(m_spd[1]), m_rev[1], m_set};
    endfunction

    function automatic logic signed [11:0] rand_tgt();
        int r;
        int v;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 12'sd0;
        if (r < 8) v = int'($urandom_range(0, 320)) - 160;
        else       v = int'($urandom_range(0, 4095)) - 2048;
        return 12'(v);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cur[s] = 0; m_dir[s] = 0; m_hold[s] = 0; m_dw[s] = 0;
            m_spd[s] = 0; m_rev[s] = 0;
        end
        m_presc = 0;
        m_set   = 1;
    endtask

    // One side, one clock edge, expressed in terms of ticks and targets
    task automatic model_side(int s, int t, bit tick);
        int nxt;
        int mv;
        bit opp;
        if (!en) begin
            m_cur[s] = 0; m_dw[s] = 0; m_hold[s] = 0;
            return;
        end
        if (!tick) return;
        if (m_hold[s]) begin
            m_dw[s]--;
            if (m_dw[s] == 0) begin
                m_hold[s] = 0;
                if (t != 0) m_dir[s] = (t < 0);
            end
            return;
        end
        opp = (t != 0) && ((t < 0) != m_dir[s]);
        mv  = t - m_cur[s];
        if (mv < 0) mv = -mv;
        if (mv > STEP) mv = STEP;
        nxt = (t > m_cur[s]) ? m_cur[s] + mv : m_cur[s] - mv;
        if (opp && (m_cur[s] * nxt <= 0)) begin
            m_cur[s]  = 0;
            m_hold[s] = 1;
            m_dw[s]   = DWELL;
        end else begin
            m_cur[s] = nxt;
        end
    endtask

    task automatic model_edge();
        int tgt[2];
        bit tick;
        bit ok;
        tgt[0] = lft_cmd;
        tgt[1] = rght_cmd;
        ok = 1;
        for (int s = 0; s < 2; s++) begin
            m_spd[s] = duty(m_cur[s]);
            m_rev[s] = m_dir[s];
            if (m_cur[s] != tgt[s] || m_hold[s]) ok = 0;
        end
        m_set   = ok;
        tick    = (m_presc == SLEW_DIV - 1);
        m_presc = tick ? 0 : m_presc + 1;
        for (int s = 0; s < 2; s++) model_side(s, tgt[s], tick);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < SLEW_DIV && m_presc != 0; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; lft_cmd = 0; rght_cmd = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (obs !== 25'h1) $display("FAIL reset got=%h exp=%h", obs, 25'h1);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_ramp();
        en = 1; lft_cmd = 12'sd100; rght_cmd = 0;
        for (int i = 1; i <= 7 * SLEW_DIV + 1; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL ramp t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
            if (i == SLEW_DIV + 1) begin
                n_total++;
                if (lft_spd !== 11'(16 + DB) || lft_rev !== 1'b0)
                    $display("FAIL ramp_first got=%0d/%0b exp=%0d/0", lft_spd, lft_rev, 16 + DB);
                else n_pass++;
            end
        end
        n_total++;
        if (lft_spd !== 11'(100 + DB) || settled !== 1'b1)
            $display("FAIL ramp_final got=%0d/%0b exp=%0d/1", lft_spd, settled, 100 + DB);
        else n_pass++;
    endtask

    task automatic test_reversal();
        lft_cmd = -12'sd32;
        for (int i = 0; i < 100; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL reversal t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (lft_spd !== 11'(32 + DB) || lft_rev !== 1'b1)
            $display("FAIL reversal_final got=%0d/%0b exp=%0d/1", lft_spd, lft_rev, 32 + DB);
        else n_pass++;
    endtask

    task automatic test_independence();
        align();
        lft_cmd = 12'sd32; rght_cmd = 12'sd48;
        for (int i = 1; i <= 80; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL indep t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
            if (i == 3 * SLEW_DIV + 1) begin
                n_total++;
                if (rght_spd !== 11'(48 + DB) || rght_rev !== 1'b0)
                    $display("FAIL indep_right got=%0d/%0b exp=%0d/0", rght_spd, rght_rev, 48 + DB);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        rght_cmd = -12'sd2048;
        for (int i = 0; i < 600; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL sat t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (rght_spd !== 11'h7FF || rght_rev !== 1'b1)
            $display("FAIL sat_final got=%0d/%0b exp=2047/1", rght_spd, rght_rev);
        else n_pass++;
        rght_cmd = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL sat_return t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        align();
        lft_cmd = 12'sd200;
        for (int i = 0; i < 2 * SLEW_DIV + 1; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL endrop_ramp t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (lft_spd !== 11'(64 + DB)) $display("FAIL endrop_mid got=%0d exp=%0d", lft_spd, 64 + DB);
        else n_pass++;
        en = 0;
        step();
        n_total++;
        if (lft_spd !== 11'(64 + DB)) $display("FAIL endrop_1clk got=%0d exp=%0d", lft_spd, 64 + DB);
        else n_pass++;
        step();
        n_total++;
        if (lft_spd !== 11'd0 || rght_spd !== 11'd0)
            $display("FAIL endrop_2clk got=%0d/%0d exp=0/0", lft_spd, rght_spd);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL endrop_low t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        en = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL endrop_resume t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_hold();
        int i;
        lft_cmd = -12'sd100;
        for (i = 0; i < 300 && !m_hold[0]; i++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL rsthold_pre t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (!m_hold[0]) $display("FAIL rsthold_timeout got=no_hold exp=hold");
        else n_pass++;
        step();
        rst_n = 0;
        #2;
        n_total++;
        if (obs !== 25'h1) $display("FAIL rsthold_async got=%h exp=%h", obs, 25'h1);
        else n_pass++;
        model_reset();
        lft_cmd = 12'sd50; rght_cmd = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 1; k <= SLEW_DIV + 1; k++) begin
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL rsthold_post t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (lft_spd !== 11'(16 + DB) || lft_rev !== 1'b0)
            $display("FAIL rsthold_first got=%0d/%0b exp=%0d/0", lft_spd, lft_rev, 16 + DB);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) lft_cmd = rand_tgt();
            if ($urandom_range(0, 19) == 0) rght_cmd = rand_tgt();
            if (en && $urandom_range(0, 199) == 0) en = 0;
            else if (!en && $urandom_range(0, 7) == 0) en = 1;
            step();
            n_total++;
            if (obs !== exp_vec()) $display("FAIL random t=%0t got=%h exp=%h", $time, obs, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp();
        test_reversal();
        test_independence();
        test_saturation();
        test_enable_drop();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mtr_cmd_shaper.md
# mtr_cmd_shaper

Conditions the signed left/right drive commands from the balance controller into the magnitude-plus-direction form consumed by the motor PWM driver. Per side it applies a slew-rate limit, a zero-crossing dwell before any direction reversal, deadband offset compensation and saturation to 11 bits. It sits directly upstream of the motor driver: its `lft_spd`/`lft_rev`/`rght_spd`/`rght_rev` outputs connect to the driver's inputs of the same name.

## Interface
- `SLEW_DIV`, default 1024: clocks per slew tick (≥2).
- `STEP`, default 16: maximum change of the internal command per tick (1..2047).
- `MIN_DUTY`, default 64: deadband offset added to nonzero magnitudes.
- `DWELL`, default 4: ticks held at zero before a reversal (≥1).
- `clk` input 1: system clock.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `en` input 1: drive enable; low forces outputs to zero.
- `lft_cmd` input 12: signed left target (−2048..2047).
- `rght_cmd` input 12: signed right target.
- `lft_spd` output 11: left duty magnitude.
- `lft_rev` output 1: left reverse.
- `rght_spd` output 11: right duty magnitude.
- `rght_rev` output 1: right reverse.
- `settled` output 1: both internal commands equal their targets and both sides are in RUN.

## Operation
- Prescaler counts 0..SLEW_DIV−1 and wraps. A tick is asserted in the cycle where count = SLEW_DIV−1. The prescaler runs regardless of `en`.
- Each side holds a signed 12-bit `cur`, a `dir` bit, and a two-state FSM (RUN, HOLD) with a dwell counter.
- RUN, on a tick:
  - If `cur` ≠ target, move `cur` toward the target by min(STEP, |target−cur|). Compute the difference in 13 bits.
  - If the new value would reach or cross zero while the target is nonzero and of opposite sign to `dir`, force `cur` to 0, load dwell = DWELL, and go to HOLD.
  - If `cur` = 0 and the target sign is opposite to `dir`, go to HOLD likewise.
- HOLD, on a tick:
  - `cur` stays 0 and dwell decrements.
  - On the tick where dwell = 1, go to RUN and set `dir` to the target sign. If the target is 0, `dir` is unchanged.
  - HOLD always completes, even if the target changes during it.
- Output mapping:
  - `spd` = 0 when `cur` = 0.
  - Otherwise `spd` = min(|cur| + MIN_DUTY, 2047), computed in 13 bits. |−2048| saturates correctly.
  - `rev` = `dir`. `rev` therefore stays stable at the old direction during HOLD.
- `en` low: next edge clears `cur`, dwell and state (→RUN). `dir` is kept. The slew ramp restarts from 0 once `en` returns high.
- The left and right sides are fully independent and share only the prescaler.

## Timing
- Reset values: `lft_spd`=`rght_spd`=0, `lft_rev`=`rght_rev`=0, `settled`=1. Internal state: prescaler 0, `cur` 0, `dir` 0, RUN.
- `cur`/state update on the edge ending a tick cycle.
- Outputs are registered: they reflect `cur`/`dir` one clock after the update.
- First tick is the SLEW_DIV-th clock after reset release.
- Reversal: the first nonzero step in the new direction happens on tick DWELL+1 after entering HOLD.
- Target change between ticks: only the value sampled in the tick cycle matters.
- `en` low to outputs zero: 2 clocks.
- Asynchronous reset mid-ramp or mid-HOLD returns everything to reset values immediately.

## Configuration
- `MTR_SHAPER_DEADBAND_EN`:
  - Defined: MIN_DUTY is added to nonzero magnitudes as described above.
  - Undefined: `spd` = min(|cur|, 2047) and MIN_DUTY is ignored.

## Test plan
- Ramp up: SLEW_DIV=4, STEP=16, MIN_DUTY=64, deadband on; `lft_cmd`=+100 → `lft_spd` 80, 96, …, 160, then 164 after 7 ticks; `lft_rev`=0; `settled` rises one clock after the final step.
- Reversal: `cur`=+32, `lft_cmd`=−32, DWELL=4 → `spd` 80, then 0 for 4 ticks with `rev`=0; then `rev`=1 and `spd`=80, then 96.
- Saturation: STEP=2047, `rght_cmd`=−2048 → `cur` crosses zero into a dwell; after the dwell `rght_spd`=2047, `rght_rev`=1. With deadband off the result is still 2047.
- Enable drop: mid-ramp at `spd`=128, set `en`=0 → `spd`=0 two clocks later; re-enable → ramp restarts at 80 on the next tick.
- Reset mid-HOLD: assert `rst_n` low during dwell → all outputs 0 and `rev`=0 immediately; after release the first step occurs SLEW_DIV clocks later.
- Independence: left reversing while right ramps 0→+48 → right reaches `spd`=112 after 3 ticks, unaffected by the left HOLD.
